// File: rtl/pc_unit_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_unit_pkg;

    localparam int unsigned DEF_WIDTH        = 32;
    localparam int unsigned DEF_RESET_VECTOR = 0;
    localparam int unsigned DEF_STEP         = 4;
    localparam int unsigned DEF_RAS_DEPTH    = 4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_e;

endpackage : pc_unit_pkg

// File: rtl/pc_unit_if.sv
// Control inputs and status outputs of the program-counter unit.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);

    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;

    // Side that issues control requests and watches the PC.
    modport master (
        output stall, redirect_valid, redirect_target, call, ret, halt, resume,
        input  pc, pc_valid, ras_empty, ras_full, ras_err
    );

    // The PC unit itself.
    modport slave (
        input  stall, redirect_valid, redirect_target, call, ret, halt, resume,
        output pc, pc_valid, ras_empty, ras_full, ras_err
    );

endinterface : pc_unit_if

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer; a push when full overwrites the oldest entry.
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic             clka,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_c,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [PTR_W-1:0] top_idx;

    // ptr_q is the next write slot; the newest entry sits just below it.
    assign top_idx = ptr_q - PTR_W'(1);
    assign top_c   = mem_q[top_idx];
    assign empty   = empty_q;
    assign full    = full_q;

    // Next-state for storage, pointer, occupancy and the registered flags.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
    end

    // State registers; reset discards every entry.
    always_ff @(posedge clka) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

endmodule : pc_ras

// File: rtl/pc_unit.sv
// Program-counter unit: sequential stepping, redirects, call/return stack, halt/resume.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter int unsigned      STEP         = DEF_STEP,
    parameter int unsigned      RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic      clka,
    input  logic      reset,
    pc_unit_if.slave  bus
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             err_q, err_d;
    logic             ras_push_c;
    logic             ras_pop_c;
    logic [WIDTH-1:0] ras_top_c;
    logic             ras_empty;
    logic             ras_full;
    logic [WIDTH-1:0] pc_seq_c;

    assign pc_seq_c = pc_q + STEP_W;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clka      (clka),
        .reset     (reset),
        .push      (ras_push_c),
        .pop       (ras_pop_c),
        .push_data (pc_seq_c),
        .top_c     (ras_top_c),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Next-PC selection: halt > redirect > return > stall > sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        err_d      = err_q;
        ras_push_c = 1'b0;
        ras_pop_c  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.halt) begin
                    state_d = HALTED;
                end else if (bus.redirect_valid) begin
                    pc_d = bus.redirect_target;
                    if (bus.call) begin
                        ras_push_c = 1'b1;
                        if (ras_full) begin
                            err_d = 1'b1;
                        end
                    end
                end else if (bus.ret && !ras_empty) begin
                    pc_d      = ras_top_c;
                    ras_pop_c = 1'b1;
                end else begin
                    // An underflowing return flags and then acts as if absent.
                    if (bus.ret) begin
                        err_d = 1'b1;
                    end
                    if (!bus.stall) begin
                        pc_d = pc_seq_c;
                    end
                end
            end
            HALTED: begin
                if (bus.resume && !bus.halt) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        pc_valid_d = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = pc_valid_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_err   = err_q;

endmodule : pc_unit
